// File: rtl/weight_dump_pkg.sv
// Shared types and defaults for the weight read-out engine.
package weight_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NET,
    HDR,
    DATA,
    CSUM
  } dump_state_e;

  localparam logic [7:0] DUMP_HDR_DEFAULT       = 8'hA5;
  localparam int         DUMP_NUM_BYTES_DEFAULT = 10;

endpackage

// File: rtl/weight_dump.sv
// Snapshots the packed weight bus once the network is idle and streams it as a
// valid/ready byte frame: header, payload, and a mod-256 checksum when WEIGHT_DUMP_CSUM_EN is defined.
module weight_dump
  import weight_dump_pkg::*;
#(
  parameter int         NUM_BYTES = DUMP_NUM_BYTES_DEFAULT,
  parameter logic [7:0] HDR_BYTE  = DUMP_HDR_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   net_idle_i,
  input  logic [NUM_BYTES*8-1:0] weights_i,
  output logic [7:0]             byte_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int            CW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int            WW       = NUM_BYTES * 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);
`ifdef WEIGHT_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  // Handshake: a byte transfers on a rising edge where valid_o and ready_i are
  // both high; byte_o/last_o/valid_o stay frozen until that edge.
  dump_state_e   state_q, state_d;
  logic [WW-1:0] snap_q, snap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
`ifdef WEIGHT_DUMP_CSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic          xfer;
  logic          take_snap;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    byte_nxt;

  assign xfer      = valid_q & ready_i;
  assign take_snap = net_idle_i & (((state_q == IDLE) & start_i) | (state_q == WAIT_NET));
  assign cnt_nxt   = cnt_q + CW'(1);
  // Shift rather than part-select so an out-of-range index can never be formed.
  assign byte_nxt  = 8'(snap_q >> (int'(cnt_nxt) * 8));

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef WEIGHT_DUMP_CSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !net_idle_i) state_d = WAIT_NET;
      end
      WAIT_NET: ;
      HDR: begin
        if (xfer) begin
          state_d = DATA;
          cnt_d   = '0;
          byte_d  = snap_q[7:0];
          last_d  = !CSUM_ON && (LAST_IDX == '0);
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef WEIGHT_DUMP_CSUM_EN
          csum_d = csum_q + byte_q;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef WEIGHT_DUMP_CSUM_EN
            state_d = CSUM;
            byte_d  = csum_q + byte_q;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            byte_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d  = cnt_nxt;
            byte_d = byte_nxt;
            last_d = !CSUM_ON && (cnt_nxt == LAST_IDX);
          end
        end
      end
`ifdef WEIGHT_DUMP_CSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          byte_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    if (take_snap) begin
      state_d = HDR;
      snap_d  = weights_i;
      cnt_d   = '0;
      byte_d  = HDR_BYTE;
      valid_d = 1'b1;
      last_d  = 1'b0;
`ifdef WEIGHT_DUMP_CSUM_EN
      csum_d  = '0;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      snap_q  <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef WEIGHT_DUMP_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef WEIGHT_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_o  = byte_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_weight_dump.sv
// Self-checking bench for weight_dump: frames are compared against a list-level
// model (header, payload bytes, optional mod-256 sum) built from the weights.
module tb_weight_dump;

  localparam int         NB  = 10;
  localparam logic [7:0] HDR = 8'hA5;
`ifdef WEIGHT_DUMP_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            net_idle_i;
  logic [NB*8-1:0] weights_i;
  logic [7:0]      byte_o;
  logic            valid_o;
  logic            ready_i;
  logic            last_o;
  logic            busy_o;
  logic            done_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       glast_q[$];

  always #5 clk_i = ~clk_i;

  weight_dump #(.NUM_BYTES(NB), .HDR_BYTE(HDR)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .net_idle_i (net_idle_i),
    .weights_i  (weights_i),
    .byte_o     (byte_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NB*8-1:0] ramp_w();
    logic [NB*8-1:0] w;
    for (int k = 0; k < NB; k++) w[k*8 +: 8] = 8'(k + 1);
    return w;
  endfunction

  function automatic logic [NB*8-1:0] rand_w();
    logic [NB*8-1:0] w;
    for (int k = 0; k < NB; k++) w[k*8 +: 8] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  // Reference frame: header, bytes 0..NB-1, then the byte sum mod 256 if enabled.
  function automatic void model(input logic [NB*8-1:0] w);
    int sum;
    sum = 0;
    exp_q.delete();
    exp_q.push_back(HDR);
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(w[k*8 +: 8]);
      sum += int'(w[k*8 +: 8]);
    end
    if (CSUM) exp_q.push_back(8'(sum % 256));
  endfunction

  task automatic start_frame(input logic [NB*8-1:0] w, input logic idle);
    weights_i  = w;
    net_idle_i = idle;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
  endtask

  // Consumer: drives ready_i, records each transfer, counts protocol slips.
  // Returns on the negedge of the cycle after the last byte (the done cycle).
  task automatic collect(input int stall_idx, input int stall_len, input bit rnd,
                         input bit ff_after_hdr,
                         output int viol, output bit done_ok, output bit timeout);
    int         stall_left;
    bit         got_last;
    bit         pend;
    logic [7:0] pb;
    logic       pl;
    got_q.delete();
    glast_q.delete();
    stall_left = stall_len;
    got_last   = 1'b0;
    pend       = 1'b0;
    pb         = '0;
    pl         = 1'b0;
    viol       = 0;
    done_ok    = 1'b0;
    timeout    = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (pend && (valid_o !== 1'b1 || byte_o !== pb || last_o !== pl)) viol++;
      if (got_last) begin
        done_ok = (done_o === 1'b1) && (busy_o === 1'b0) && (valid_o === 1'b0);
        timeout = 1'b0;
        break;
      end
      if (done_o !== 1'b0) viol++;
      if (valid_o === 1'b1 && busy_o !== 1'b1) viol++;
      if (valid_o === 1'b1 && got_q.size() == stall_idx && stall_left > 0) begin
        ready_i = 1'b0;
        stall_left--;
      end else begin
        ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (valid_o === 1'b1 && ready_i) begin
        got_q.push_back(byte_o);
        glast_q.push_back(last_o);
        if (last_o === 1'b1) got_last = 1'b1;
        if (ff_after_hdr && got_q.size() == 1) weights_i = '1;
        pend = 1'b0;
      end else begin
        pend = (valid_o === 1'b1);
        pb   = byte_o;
        pl   = last_o;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i      = 1'b0;
    start_i    = 1'b1;
    net_idle_i = 1'b1;
    ready_i    = 1'b0;
    weights_i  = '0;
    repeat (3) @(negedge clk_i);
    total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", byte_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    start_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk_i);
    total++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL reset_release valid=%b busy=%b exp=0/0", valid_o, busy_o);
    end
  endtask

  task automatic test_normal();
    int viol; bit done_ok, tmo;
    model(ramp_w());
    start_frame(ramp_w(), 1'b1);
    total++; if (valid_o !== 1'b1 || byte_o !== HDR) begin
      bad++; $display("FAIL normal_latency valid=%b byte=%h exp=1/%h", valid_o, byte_o, HDR);
    end
    collect(-1, 0, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL normal_len got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), tmo);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || glast_q[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL normal_byte[%0d] got=%h/last%b exp=%h/last%b", i, got_q[i], glast_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
    total++; if (!done_ok || viol != 0) begin bad++; $display("FAIL normal_done done_ok=%0b viol=%0d exp=1/0", done_ok, viol); end
    @(negedge clk_i);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL normal_done_pulse got=%b exp=0", done_o); end
  endtask

  task automatic test_backpressure();
    int viol; bit done_ok, tmo;
    model(ramp_w());
    start_frame(ramp_w(), 1'b1);
    collect(3, 3, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_len got=%0d exp=%0d timeout=%0b", got_q.size(), exp_q.size(), tmo);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || glast_q[i] !== (i == exp_q.size() - 1)) begin
        bad++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++; if (!done_ok || viol != 0) begin bad++; $display("FAIL bp_hold done_ok=%0b viol=%0d exp=1/0", done_ok, viol); end
  endtask

  task automatic test_wait_net();
    int viol; bit done_ok, tmo;
    logic [NB*8-1:0] w_rise;
    @(negedge clk_i);
    start_frame(rand_w(), 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
        bad++; $display("FAIL wait_net[%0d] busy=%b valid=%b exp=1/0", i, busy_o, valid_o);
      end
      weights_i = rand_w();
      @(negedge clk_i);
    end
    w_rise     = rand_w();
    weights_i  = w_rise;
    net_idle_i = 1'b1;
    @(negedge clk_i);
    weights_i  = rand_w();
    total++; if (valid_o !== 1'b1 || byte_o !== HDR) begin
      bad++; $display("FAIL wait_net_hdr valid=%b byte=%h exp=1/%h", valid_o, byte_o, HDR);
    end
    model(w_rise);
    collect(-1, 0, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size() || !done_ok || viol != 0) begin
      bad++; $display("FAIL wait_net_frame len=%0d exp=%0d done_ok=%0b viol=%0d", got_q.size(), exp_q.size(), done_ok, viol);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wait_net_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_isolation();
    int viol; bit done_ok, tmo;
    @(negedge clk_i);
    model(ramp_w());
    start_frame(ramp_w(), 1'b1);
    collect(-1, 0, 1'b0, 1'b1, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size() || !done_ok) begin
      bad++; $display("FAIL iso_len got=%0d exp=%0d done_ok=%0b", got_q.size(), exp_q.size(), done_ok);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL iso_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int viol; bit done_ok, tmo, found;
    @(negedge clk_i);
    start_frame(ramp_w(), 1'b1);
    ready_i = 1'b1;
    found   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (valid_o === 1'b1 && byte_o === 8'h05) begin found = 1'b1; break; end
      @(negedge clk_i);
    end
    total++; if (!found) begin bad++; $display("FAIL mrst_reach got=%h exp=05", byte_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    total++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL mrst_abort valid=%b busy=%b done=%b exp=0/0/0", valid_o, busy_o, done_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      total++; if (done_o !== 1'b0 || valid_o !== 1'b0) begin
        bad++; $display("FAIL mrst_quiet[%0d] done=%b valid=%b exp=0/0", c, done_o, valid_o);
      end
    end
    model(ramp_w());
    start_frame(ramp_w(), 1'b1);
    collect(-1, 0, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size() || !done_ok || viol != 0) begin
      bad++; $display("FAIL mrst_refrm len=%0d exp=%0d done_ok=%0b viol=%0d", got_q.size(), exp_q.size(), done_ok, viol);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL mrst_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int viol; bit done_ok, tmo;
    logic [NB*8-1:0] w2;
    @(negedge clk_i);
    model(ramp_w());
    start_frame(ramp_w(), 1'b1);
    collect(-1, 0, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size() || !done_ok) begin
      bad++; $display("FAIL b2b_first len=%0d exp=%0d done_ok=%0b", got_q.size(), exp_q.size(), done_ok);
    end
    total++; if (!tmo && got_q.size() == exp_q.size() && (got_q[NB] !== 8'h0A || glast_q[NB] !== !CSUM)) begin
      bad++; $display("FAIL b2b_last byte=%h last=%b exp=0a/%b", got_q[NB], glast_q[NB], !CSUM);
    end
    w2 = rand_w();
    start_frame(w2, 1'b1);
    total++; if (valid_o !== 1'b1 || byte_o !== HDR) begin
      bad++; $display("FAIL b2b_restart valid=%b byte=%h exp=1/%h", valid_o, byte_o, HDR);
    end
    model(w2);
    collect(-1, 0, 1'b0, 1'b0, viol, done_ok, tmo);
    total++; if (tmo || got_q.size() != exp_q.size() || !done_ok || viol != 0) begin
      bad++; $display("FAIL b2b_second len=%0d exp=%0d done_ok=%0b viol=%0d", got_q.size(), exp_q.size(), done_ok, viol);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int viol; bit done_ok, tmo;
    logic [NB*8-1:0] w;
    for (int f = 0; f < 6; f++) begin
      @(negedge clk_i);
      w = rand_w();
      model(w);
      start_frame(w, 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk_i);
      net_idle_i = 1'b1;
      @(negedge clk_i);
      weights_i = rand_w();
      collect(int'($urandom_range(0, NB)), int'($urandom_range(0, 4)), 1'b1, 1'b0, viol, done_ok, tmo);
      total++; if (tmo || got_q.size() != exp_q.size() || !done_ok || viol != 0) begin
        bad++; $display("FAIL rand%0d_frame len=%0d exp=%0d done_ok=%0b viol=%0d", f, got_q.size(), exp_q.size(), done_ok, viol);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i] || glast_q[i] !== (i == exp_q.size() - 1)) begin
          bad++; $display("FAIL rand%0d_byte[%0d] got=%h/last%b exp=%h", f, i, got_q[i], glast_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_backpressure();
    test_wait_net();
    test_isolation();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
